// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encodings and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width; never below one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Half adder and the full-adder cell built from two of them plus an OR.
// The full-adder cell is the only arithmetic logic in the serial adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  half_adder u_ha0 (.a(a),    .b(b),   .s(s1_s), .c(c1_s));
  half_adder u_ha1 (.a(s1_s), .b(cin), .s(s),    .c(c2_s));

  assign cout = c1_s | c2_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one operand bit per clock through a single
// full-adder cell and a carry flop, with a start/busy/done handshake.
// Subtraction is a + ~b + 1, so cout=1 means "no borrow".
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             last_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  // Upper WIDTH-1 bits of the partially assembled result; the incoming
  // bit completes it to WIDTH bits, the oldest bit falls off the bottom.
  logic [WIDTH-2:0] res_r;
  logic             carry_r;
  logic             msb_carry_r;
  logic [CW-1:0]    cnt_r;

  logic             fa_s_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_next_s;

  full_adder_cell u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  assign res_next_s = {fa_s_s, res_r};

  // State register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode, start acceptance and last-bit detection.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = S_DONE;
          last_s  = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting, carry tracking and result commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      carry_r     <= 1'b0;
      msb_carry_r <= 1'b0;
      cnt_r       <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
    end else if (accept_s) begin
      a_r         <= a;
      b_r         <= b ^ {WIDTH{sub}};
      carry_r     <= sub ? 1'b1 : cin;
      msb_carry_r <= 1'b0;
      cnt_r       <= '0;
    end else if (state_r == S_RUN) begin
      a_r     <= {1'b0, a_r[WIDTH-1:1]};
      b_r     <= {1'b0, b_r[WIDTH-1:1]};
      res_r   <= res_next_s[WIDTH-1:1];
      carry_r <= fa_cout_s;
      // Carry leaving bit WIDTH-2 is the carry into the MSB.
      if (cnt_r == PRE_CNT) begin
        msb_carry_r <= fa_cout_s;
      end
      if (last_s) begin
        sum   <= res_next_s;
        cout  <= fa_cout_s;
        ovf   <= msb_carry_r ^ fa_cout_s;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ONE_CNT;
      end
    end
  end

  // Registered handshake outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s == S_RUN);
      done <= last_s;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Launch one operation, wait (bounded) for done, check latency and results.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic cv,
                        input logic [7:0] es, input logic ec, input logic eo);
    int n;
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pulses;
    int first_done;
    int done_at[3];

    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);

    // start together with reset must be ignored
    start = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(busy), 32'd0);

    run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_cin",   8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Start pulse and operand change during RUN cycle 3 are ignored
    a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    first_done = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 3) begin
        start = 1'b1; a = 8'hAA; sub = 1'b1;
        chk("ign_sum_held", 32'(sum), 32'h7F);
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (first_done == 0) begin
          first_done = t;
        end
        chk("ign_sum", 32'(sum), 32'h30);
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_done_at", 32'(first_done), 32'd8);

    // Reset during RUN cycle 4 aborts without a done pulse
    a = 8'hFF; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
      end
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // start held high: repeated operations every WIDTH+1 cycles
    a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    pulses = 0;
    for (int t = 1; t <= 27; t++) begin
      tick();
      if (done === 1'b1) begin
        if (pulses < 3) begin
          done_at[pulses] = t;
        end
        pulses++;
        chk("held_sum", 32'(sum), 32'h02);
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd3);
    if (pulses >= 3) begin
      chk("held_first", 32'(done_at[0]), 32'd8);
      chk("held_per1", 32'(done_at[1] - done_at[0]), 32'd9);
      chk("held_per2", 32'(done_at[2] - done_at[1]), 32'd9);
    end else begin
      n_cmp++;
      n_err++;
      $error("FAIL held_timing: observed=%0d pulses expected=3", pulses);
    end
    for (int t = 0; t < 10; t++) begin
      tick();
    end
    chk("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
